dense_output_layer: RTL and testbench
=====================================

Name: dense_output_layer

Overview:
- Final fully-connected layer of the classifier datapath: streams signed 8-bit input features and multiplies each feature against a row of per-class weights fetched from an external synchronous ROM.
- Accumulates NUM_OUTPUTS signed 32-bit dot products, each seeded with a bias.
- Presents the finished activation vector, held stable, to the downstream argmax/classification stage, which reads it combinationally.

Parameters:
- NUM_INPUTS, 32, number of input features per inference (>=2)
- NUM_OUTPUTS, 10, number of classes/accumulators
- ADDR_W, $clog2(NUM_INPUTS), weight ROM address width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins an inference when idle
- biases  input  signed [31:0] x NUM_OUTPUTS  per-class bias; sampled on accepted start
- busy  output  1  high from accepted start until output handshake completes
- in_valid  input  1  feature valid
- in_ready  output  1  block accepts a feature
- in_data  input  signed 8  feature value
- in_last  input  1  marks the final feature of an inference
- weight_addr  output  ADDR_W  ROM row address (feature index)
- weight_data  input  NUM_OUTPUTS*8  packed signed 8-bit weights, class j at bits [8j+7:8j]; valid 1 cycle after weight_addr
- out_valid  output  1  activations complete
- out_ready  input  1  downstream consumed result
- activations  output  signed [31:0] x NUM_OUTPUTS  accumulated results
- length_err  output  1  valid with out_valid; in_last disagreed with NUM_INPUTS

Behaviour:
- Reset: state IDLE; busy, in_ready, out_valid, and length_err are 0; weight_addr, the feature counter, the pipeline register, and all accumulators/activations are 0. Reset overrides everything, including a mid-inference or mid-handshake state; there is no partial output.
- IDLE:
  - start=1 loads acc[j]=biases[j] and counter=0, then goes to ACCUM.
  - start is ignored in every other state.
  - activations hold their previous values.
- ACCUM:
  - in_ready=1 and weight_addr=counter (combinational from the counter).
  - Accepted feature (in_valid&in_ready): register in_data and a pipe-valid bit; counter++.
  - Next cycle, when pipe-valid: acc[j] += sext32(x_reg * w_j) for every j in parallel. The product is signed 16-bit, sign-extended; the 32-bit add wraps two's-complement with no saturation.
  - Leave ACCUM after accepting the feature where in_last=1 or counter==NUM_INPUTS-1, whichever comes first.
  - length_err is set if exactly one of those two conditions holds on that feature.
  - Bubbles (in_valid=0) are legal; the accumulators are untouched.
- DRAIN (1 cycle): in_ready=0; the final pending product is accumulated; go to DONE.
- DONE:
  - out_valid=1; activations=acc; length_err is held.
  - On out_ready=1, go to IDLE the following cycle: out_valid, busy, and length_err clear.
  - activations keep their values until the next accepted start reloads the biases.
  - out_valid stays high indefinitely while out_ready=0.
- Latency: out_valid rises 2 cycles after the last feature is accepted. Back-to-back streaming gives a throughput of 1 feature/cycle.
- busy is 1 in ACCUM, DRAIN, and DONE.
- The counter never exceeds NUM_INPUTS-1, so weight_addr never wraps.

Test Plan:
- NUM_INPUTS=4, NUM_OUTPUTS=10; biases all 0; features 1,2,3,4 (last on 4); w_j=j for all rows -> acc[j]=10*j; out_valid 2 cycles after the 4th accept; length_err=0.
- Signed/bias check:
  - bias[3]=-100; features -128,127,-1,0; row weights for class 3 = -128,-128,127,5.
  - Expected acc[3]=-100+16384-16256-127+0=-99.
  - Expected bias[0]=0 with weights 0 -> acc[0]=0.
- Bubbles and backpressure: random in_valid gaps and out_ready held low 20 cycles -> identical sums; activations and out_valid stable throughout; busy high until the cycle after out_ready.
- Length mismatch:
  - in_last on the 2nd feature -> finish early, sums over 2 features, length_err=1.
  - No in_last by the 4th feature -> finish at the 4th, length_err=1.
- Reset mid-inference after 2 features, then a full new run -> outputs zero after reset; the new run's results exclude the old partial sums.
- start pulsed during ACCUM and DONE is ignored, with sums unchanged.
- Wrap check: bias=0x7FFFFFF0, one feature 127 * weight 127 -> result wraps to 0x7FFFFFF0+16129 modulo 2^32 (negative).

Source files
------------

// File: rtl/dense_output_layer.sv
// Final fully-connected classifier layer: streams signed 8-bit features against
// per-class weight rows from a synchronous ROM and accumulates biased 32-bit dot products.
module dense_output_layer #(
   parameter int NUM_INPUTS  = 32,
   parameter int NUM_OUTPUTS = 10,
   parameter int ADDR_W      = $clog2(NUM_INPUTS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic signed [31:0]         biases [NUM_OUTPUTS],
   output logic                       busy,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [7:0]          in_data,
   input  logic                       in_last,
   output logic [ADDR_W-1:0]          weight_addr,
   input  logic [NUM_OUTPUTS*8-1:0]   weight_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [31:0]         activations [NUM_OUTPUTS],
   output logic                       length_err
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_INPUTS - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   state_t                    state, state_nxt;
   logic [ADDR_W-1:0]         count;
   logic signed [7:0]         x_reg;
   logic                      pipe_valid;
   logic signed [31:0]        acc  [NUM_OUTPUTS];
   logic signed [15:0]        prod [NUM_OUTPUTS];
   logic                      accept;
   logic                      at_end;
   logic                      final_feat;

   assign accept      = in_valid && (state == ACCUM);
   assign at_end      = (count == LAST_IDX);
   assign final_feat  = in_last || at_end;
   assign weight_addr = count;
   assign activations = acc;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (accept && final_feat) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // weight_data lines up with x_reg: both refer to the feature accepted last cycle
   always_comb begin
      for (int unsigned j = 0; j < NUM_OUTPUTS; j++)
         prod[j] = x_reg * $signed(weight_data[8*j +: 8]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count      <= '0;
         x_reg      <= '0;
         pipe_valid <= 1'b0;
         length_err <= 1'b0;
         for (int unsigned j = 0; j < NUM_OUTPUTS; j++) acc[j] <= '0;
      end else begin
         pipe_valid <= accept;
         if (accept) x_reg <= in_data;

         if (state == IDLE && start) begin
            count <= '0;
            for (int unsigned j = 0; j < NUM_OUTPUTS; j++) acc[j] <= biases[j];
         end else if (pipe_valid) begin
            for (int unsigned j = 0; j < NUM_OUTPUTS; j++)
               acc[j] <= acc[j] + {{16{prod[j][15]}}, prod[j]};
         end

         // the counter holds on the final feature so it never passes NUM_INPUTS-1
         if (accept && !final_feat) count <= count + ADDR_W'(1);

         if (accept && final_feat)            length_err <= in_last ^ at_end;
         else if (state == DONE && out_ready) length_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dense_output_layer.sv
// Directed self-checking bench for dense_output_layer with NUM_INPUTS=4, NUM_OUTPUTS=10.
module tb_dense_output_layer;

   localparam int NI = 4;
   localparam int NO = 10;

   logic                 clk = 1'b0;
   logic                 reset, start, in_valid, in_last, out_ready;
   logic signed [7:0]    in_data;
   logic signed [31:0]   biases [NO];
   logic                 busy, in_ready, out_valid, length_err;
   logic [1:0]           weight_addr;
   logic [NO*8-1:0]      weight_data;
   logic signed [31:0]   activations [NO];
   logic signed [7:0]    rom [NI][NO];
   int                   tests = 0;
   int                   fails = 0;

   dense_output_layer #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) dut (
      .clk(clk), .reset(reset), .start(start), .biases(biases), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .weight_addr(weight_addr), .weight_data(weight_data), .out_valid(out_valid),
      .out_ready(out_ready), .activations(activations), .length_err(length_err)
   );

   always #5 clk = ~clk;

   // synchronous weight ROM
   always @(posedge clk)
      for (int j = 0; j < NO; j++) weight_data[8*j +: 8] <= rom[weight_addr][j];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rom_ramp();
      for (int i = 0; i < NI; i++)
         for (int j = 0; j < NO; j++) rom[i][j] = 8'(j);
   endtask

   task automatic set_biases(input int v);
      for (int j = 0; j < NO; j++) biases[j] = v;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic signed [7:0] d, input logic l);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("in_ready_wait", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("out_valid_wait", out_valid, 1);
   endtask

   task automatic finish_hs(input string tag);
      out_ready = 1'b1;
      tick();
      chk({tag, "_ov_clr"}, out_valid, 0);
      chk({tag, "_busy_clr"}, busy, 0);
      chk({tag, "_lerr_clr"}, length_err, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_data = '0; out_ready = 1'b0;
      set_biases(0);
      rom_ramp();
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_length_err", length_err, 0);
      chk("rst_weight_addr", weight_addr, 0);
      for (int j = 0; j < NO; j++) chk($sformatf("rst_act%0d", j), activations[j], 0);
      reset = 1'b0;
      tick();

      // basic run, with start pulses in ACCUM and DONE that must be ignored
      do_start();
      chk("t1_busy", busy, 1);
      send(1, 0);
      send(2, 0);
      set_biases(7);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_ign_busy", busy, 1);
      chk("t1_ign_in_ready", in_ready, 1);
      send(3, 0);
      send(4, 1);
      chk("t1_lat_drain", out_valid, 0);
      chk("t1_drain_in_ready", in_ready, 0);
      tick();
      chk("t1_lat_done", out_valid, 1);
      chk("t1_length_err", length_err, 0);
      for (int j = 0; j < NO; j++) chk($sformatf("t1_act%0d", j), activations[j], 10 * j);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_done_ign_ov", out_valid, 1);
      chk("t1_done_ign_act9", activations[9], 90);
      finish_hs("t1");
      chk("t1_idle_hold_act7", activations[7], 70);

      // signed products and bias
      set_biases(0);
      biases[3] = -100;
      for (int i = 0; i < NI; i++)
         for (int j = 0; j < NO; j++) rom[i][j] = (j == 0) ? 8'sd0 : 8'sd1;
      rom[0][3] = -128; rom[1][3] = -128; rom[2][3] = 127; rom[3][3] = 5;
      do_start();
      send(-128, 0);
      send(127, 0);
      send(-1, 0);
      send(0, 1);
      wait_out();
      chk("t2_act3", activations[3], -99);
      chk("t2_act0", activations[0], 0);
      chk("t2_act5", activations[5], -2);
      chk("t2_length_err", length_err, 0);
      finish_hs("t2");

      // bubbles and backpressure
      rom_ramp();
      set_biases(0);
      do_start();
      send(1, 0);
      tick(); tick();
      send(2, 0);
      send(3, 0);
      tick(); tick(); tick();
      send(4, 1);
      wait_out();
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("t3_hold_ov%0d", k), out_valid, 1);
         chk($sformatf("t3_hold_act9_%0d", k), activations[9], 90);
         chk($sformatf("t3_hold_busy%0d", k), busy, 1);
         tick();
      end
      chk("t3_act3", activations[3], 30);
      out_ready = 1'b1;
      chk("t3_busy_before", busy, 1);
      tick();
      chk("t3_ov_after", out_valid, 0);
      chk("t3_busy_after", busy, 0);
      out_ready = 1'b0;

      // in_last early
      do_start();
      send(1, 0);
      send(2, 1);
      wait_out();
      chk("t4_length_err", length_err, 1);
      for (int j = 0; j < NO; j++) chk($sformatf("t4_act%0d", j), activations[j], 3 * j);
      finish_hs("t4");

      // no in_last by the final feature
      do_start();
      send(1, 0);
      send(2, 0);
      send(3, 0);
      send(4, 0);
      chk("t5_in_ready_drop", in_ready, 0);
      wait_out();
      chk("t5_length_err", length_err, 1);
      chk("t5_act9", activations[9], 90);
      chk("t5_act1", activations[1], 10);
      finish_hs("t5");

      // reset mid-inference, then a clean run
      set_biases(3);
      do_start();
      send(5, 0);
      send(5, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_ov", out_valid, 0);
      chk("t6_in_ready", in_ready, 0);
      chk("t6_act9", activations[9], 0);
      chk("t6_act4", activations[4], 0);
      chk("t6_weight_addr", weight_addr, 0);
      set_biases(0);
      do_start();
      send(1, 0);
      send(2, 0);
      send(3, 0);
      send(4, 1);
      wait_out();
      chk("t6_new_act9", activations[9], 90);
      chk("t6_new_act2", activations[2], 20);
      chk("t6_new_lerr", length_err, 0);
      finish_hs("t6");

      // two's-complement wrap
      set_biases(0);
      biases[0] = 32'sh7FFFFFF0;
      for (int i = 0; i < NI; i++)
         for (int j = 0; j < NO; j++) rom[i][j] = 8'sd0;
      rom[0][0] = 127;
      do_start();
      send(127, 1);
      wait_out();
      chk("t7_wrap_act0", activations[0], 32'h80003EF1);
      chk("t7_act1", activations[1], 0);
      chk("t7_length_err", length_err, 1);
      finish_hs("t7");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
